// File: rtl/ray_sphere_tester.sv
// Ray/sphere intersection tester: accepts one ray per handshake, accumulates the
// quadratic coefficients one axis per cycle, then emits hit flag, colour and pixel index.
module ray_sphere_tester #(
    parameter int          DIR_W      = 16,
    parameter logic [23:0] HIT_COLOUR = 24'hFF0000,
    parameter logic [23:0] BG_COLOUR  = 24'h000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ray_dir_x,
    input  logic [31:0] ray_dir_y,
    input  logic [31:0] ray_dir_z,
    input  logic [31:0] pixel_index,
    input  logic [10:0] camera_pos_x,
    input  logic [10:0] camera_pos_y,
    input  logic [10:0] camera_pos_z,
    input  logic [10:0] sphere_x,
    input  logic [10:0] sphere_y,
    input  logic [10:0] sphere_z,
    input  logic [10:0] sphere_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_hit,
    output logic [23:0] out_colour,
    output logic [31:0] out_index
);

    typedef enum logic [2:0] {IDLE, ACC_X, ACC_Y, ACC_Z, DISC, OUT} state_t;

    state_t                   state_q, state_d;
    logic signed [DIR_W-1:0]  dx_q, dx_d, dy_q, dy_d, dz_q, dz_d;
    logic signed [11:0]       ocx_q, ocx_d, ocy_q, ocy_d, ocz_q, ocz_d;
    logic [10:0]              r_q, r_d;
    logic [31:0]              idx_q, idx_d;
    logic signed [63:0]       a_q, a_d, b_q, b_d, c_q, c_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_hit_q, out_hit_d;
    logic [23:0]              out_colour_q, out_colour_d;
    logic [31:0]              out_index_q, out_index_d;

    logic signed [DIR_W-1:0]  d_sel;
    logic signed [11:0]       oc_sel;
    logic signed [63:0]       d_ext, oc_ext, c_fin;
    logic [21:0]              r_sq;
    logic signed [127:0]      a_w, b_w, c_w, disc;
    logic                     hit_w;
    logic                     unused_dir_bits;

    // Only the low DIR_W bits of each component carry the direction.
    assign unused_dir_bits = ^{ray_dir_x[31:DIR_W], ray_dir_y[31:DIR_W], ray_dir_z[31:DIR_W]};

    assign in_ready   = (state_q == IDLE) && !reset;
    assign out_valid  = out_valid_q;
    assign out_hit    = out_hit_q;
    assign out_colour = out_colour_q;
    assign out_index  = out_index_q;

    always_comb begin
        case (state_q)
            ACC_Y:   begin d_sel = dy_q; oc_sel = ocy_q; end
            ACC_Z:   begin d_sel = dz_q; oc_sel = ocz_q; end
            default: begin d_sel = dx_q; oc_sel = ocx_q; end
        endcase
        d_ext  = {{(64-DIR_W){d_sel[DIR_W-1]}}, d_sel};
        oc_ext = {{52{oc_sel[11]}}, oc_sel};
        r_sq   = {11'd0, r_q} * {11'd0, r_q};
        c_fin  = c_q - {42'd0, r_sq};
        a_w    = {{64{a_q[63]}}, a_q};
        b_w    = {{64{b_q[63]}}, b_q};
        c_w    = {{64{c_fin[63]}}, c_fin};
        disc   = b_w * b_w - a_w * c_w;
        // c<0 means the camera sits inside the sphere; b<0 means it lies ahead.
        hit_w  = (disc >= 0) && ((c_fin < 0) || (b_q < 0));
    end

    always_comb begin
        state_d      = state_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        dz_d         = dz_q;
        ocx_d        = ocx_q;
        ocy_d        = ocy_q;
        ocz_d        = ocz_q;
        r_d          = r_q;
        idx_d        = idx_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        out_valid_d  = out_valid_q;
        out_hit_d    = out_hit_q;
        out_colour_d = out_colour_q;
        out_index_d  = out_index_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    dx_d    = ray_dir_x[DIR_W-1:0];
                    dy_d    = ray_dir_y[DIR_W-1:0];
                    dz_d    = ray_dir_z[DIR_W-1:0];
                    ocx_d   = {1'b0, camera_pos_x} - {1'b0, sphere_x};
                    ocy_d   = {1'b0, camera_pos_y} - {1'b0, sphere_y};
                    ocz_d   = {1'b0, camera_pos_z} - {1'b0, sphere_z};
                    r_d     = sphere_r;
                    idx_d   = pixel_index;
                    a_d     = '0;
                    b_d     = '0;
                    c_d     = '0;
                    state_d = ACC_X;
                end
            end
            ACC_X, ACC_Y, ACC_Z: begin
                a_d = a_q + d_ext * d_ext;
                b_d = b_q + d_ext * oc_ext;
                c_d = c_q + oc_ext * oc_ext;
                case (state_q)
                    ACC_X:   state_d = ACC_Y;
                    ACC_Y:   state_d = ACC_Z;
                    default: state_d = DISC;
                endcase
            end
            DISC: begin
                c_d          = c_fin;
                out_valid_d  = 1'b1;
                out_hit_d    = hit_w;
                out_colour_d = hit_w ? HIT_COLOUR : BG_COLOUR;
                out_index_d  = idx_q;
                state_d      = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            dx_q         <= '0;
            dy_q         <= '0;
            dz_q         <= '0;
            ocx_q        <= '0;
            ocy_q        <= '0;
            ocz_q        <= '0;
            r_q          <= '0;
            idx_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            out_valid_q  <= 1'b0;
            out_hit_q    <= 1'b0;
            out_colour_q <= '0;
            out_index_q  <= '0;
        end else begin
            state_q      <= state_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            dz_q         <= dz_d;
            ocx_q        <= ocx_d;
            ocy_q        <= ocy_d;
            ocz_q        <= ocz_d;
            r_q          <= r_d;
            idx_q        <= idx_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            out_valid_q  <= out_valid_d;
            out_hit_q    <= out_hit_d;
            out_colour_q <= out_colour_d;
            out_index_q  <= out_index_d;
        end
    end

endmodule

// File: tb/tb_ray_sphere_tester.sv
// Bench for ray_sphere_tester: directed scenarios plus randomized rays checked
// against a dot-product reference model through an in-order scoreboard.
module tb_ray_sphere_tester;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] ray_dir_x = '0, ray_dir_y = '0, ray_dir_z = '0, pixel_index = '0;
    logic [10:0] camera_pos_x = '0, camera_pos_y = '0, camera_pos_z = '0;
    logic [10:0] sphere_x = '0, sphere_y = '0, sphere_z = '0, sphere_r = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_hit;
    logic [23:0] out_colour;
    logic [31:0] out_index;

    ray_sphere_tester dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ray_dir_x(ray_dir_x), .ray_dir_y(ray_dir_y), .ray_dir_z(ray_dir_z),
        .pixel_index(pixel_index),
        .camera_pos_x(camera_pos_x), .camera_pos_y(camera_pos_y), .camera_pos_z(camera_pos_z),
        .sphere_x(sphere_x), .sphere_y(sphere_y), .sphere_z(sphere_z), .sphere_r(sphere_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
        .out_colour(out_colour), .out_index(out_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
    bit b2b = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: a = d.d, b = d.oc, c = oc.oc - r^2, disc = b^2 - a*c
    function automatic bit model_hit(input logic [31:0] dx, dy, dz,
                                     input logic [10:0] cx, cy, cz, sx, sy, sz, r,
                                     output longint disc_o);
        longint d[3], oc[3], a, b, c;
        d[0] = longint'(shortint'(dx[15:0]));
        d[1] = longint'(shortint'(dy[15:0]));
        d[2] = longint'(shortint'(dz[15:0]));
        oc[0] = longint'(cx) - longint'(sx);
        oc[1] = longint'(cy) - longint'(sy);
        oc[2] = longint'(cz) - longint'(sz);
        a = 0; b = 0; c = 0;
        for (int i = 0; i < 3; i++) begin
            a += d[i] * d[i];
            b += d[i] * oc[i];
            c += oc[i] * oc[i];
        end
        c -= longint'(r) * longint'(r);
        disc_o = b * b - a * c;
        return (disc_o >= 0) && ((c < 0) || (b < 0));
    endfunction

    typedef struct {
        logic        hit;
        logic [31:0] idx;
        int          acc;
    } exp_t;
    exp_t q[$];

    // Scoreboard / protocol monitor, sampled on the falling edge.
    logic        stall = 1'b0, prev_ov = 1'b0, prev_hs = 1'b0;
    logic        h_hit;
    logic [23:0] h_col;
    logic [31:0] h_idx;
    int          last_hs = -1;
    always @(negedge clk) begin
        exp_t   e;
        longint dsc;
        if (reset) begin
            q.delete();
            stall = 1'b0; prev_ov = 1'b0; prev_hs = 1'b0;
        end else begin
            if (!b2b) last_hs = -1;
            if (prev_hs) check("in_ready_after_handshake", {63'd0, in_ready}, 64'd1);
            if (out_valid) begin
                check("in_ready_while_busy", {63'd0, in_ready}, 64'd0);
                if (!prev_ov && q.size() > 0)
                    check("latency", 64'(cyc - q[0].acc), 64'd5);
                if (stall) begin
                    check("hold_hit", {63'd0, out_hit}, {63'd0, h_hit});
                    check("hold_colour", {40'd0, out_colour}, {40'd0, h_col});
                    check("hold_index", {32'd0, out_index}, {32'd0, h_idx});
                end
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL stale_result: got index %0d expected no result", out_index);
                end else begin
                    e = q.pop_front();
                    check("sb_hit", {63'd0, out_hit}, {63'd0, e.hit});
                    check("sb_colour", {40'd0, out_colour}, e.hit ? 64'hFF0000 : 64'h0);
                    check("sb_index", {32'd0, out_index}, {32'd0, e.idx});
                    if (b2b && last_hs >= 0) check("b2b_spacing", 64'(cyc - last_hs), 64'd6);
                    last_hs = cyc;
                end
            end
            if (in_valid && in_ready) begin
                e.hit = model_hit(ray_dir_x, ray_dir_y, ray_dir_z, camera_pos_x, camera_pos_y,
                                  camera_pos_z, sphere_x, sphere_y, sphere_z, sphere_r, dsc);
                e.idx = pixel_index;
                e.acc = cyc;
                q.push_back(e);
            end
            stall   = out_valid && !out_ready;
            h_hit   = out_hit; h_col = out_colour; h_idx = out_index;
            prev_ov = out_valid;
            prev_hs = out_valid && out_ready;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic scene(input int cx, cy, cz, sx, sy, sz, r);
        camera_pos_x = 11'(cx); camera_pos_y = 11'(cy); camera_pos_z = 11'(cz);
        sphere_x = 11'(sx); sphere_y = 11'(sy); sphere_z = 11'(sz); sphere_r = 11'(r);
    endtask

    // Drive one ray until accepted, then scramble the scene to prove it was captured.
    task automatic send(input logic [31:0] dx, dy, dz, idx);
        bit acc = 1'b0;
        ray_dir_x = dx; ray_dir_y = dy; ray_dir_z = dz; pixel_index = idx;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            compared++; mismatched++;
            $display("FAIL accept_timeout: got no accept expected accept of index %0d", idx);
        end
        scene($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
              $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
              $urandom_range(0, 2047));
        ray_dir_x = $urandom; ray_dir_y = $urandom; ray_dir_z = $urandom;
    endtask

    task automatic wait_out(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk); seen = out_valid;
        end
        if (!seen) begin
            compared++; mismatched++;
            $display("FAIL %s_timeout: got no out_valid expected out_valid", nm);
        end
    endtask

    task automatic run_one(input string nm, input logic [31:0] dx, dy, dz, idx, input bit exp_hit);
        send(dx, dy, dz, idx);
        wait_out(nm);
        check({nm, "_hit"}, {63'd0, out_hit}, {63'd0, exp_hit});
        check({nm, "_colour"}, {40'd0, out_colour}, exp_hit ? 64'hFF0000 : 64'h0);
        check({nm, "_index"}, {32'd0, out_index}, {32'd0, idx});
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rdir(input int v);
        logic [15:0] hi;
        hi = 16'($urandom);
        return {hi, 16'(v)};
    endfunction

    initial begin
        longint dsc;
        bit     mh;
        logic        s_hit;
        logic [31:0] s_idx;
        int vx, vy, vz;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_hit", {63'd0, out_hit}, 64'd0);
        check("rst_out_colour", {40'd0, out_colour}, 64'd0);
        check("rst_out_index", {32'd0, out_index}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_release", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        // Hand-computed values pinning the reference model.
        mh = model_hit(0, 0, 1, 0, 0, 0, 0, 0, 100, 10, dsc);
        check("model_s1_disc", 64'(dsc), 64'd100);
        check("model_s1_hit", {63'd0, mh}, 64'd1);
        mh = model_hit(0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 100, 10, dsc);
        check("model_behind_hit", {63'd0, mh}, 64'd0);
        mh = model_hit(0, 0, 1, 0, 0, 0, 10, 0, 100, 10, dsc);
        check("model_tangent_disc", 64'(dsc), 64'd0);
        check("model_tangent_hit", {63'd0, mh}, 64'd1);
        mh = model_hit(0, 10, 1, 0, 0, 0, 0, 0, 100, 10, dsc);
        check("model_miss_hit", {63'd0, mh}, 64'd0);

        scene(0, 0, 0, 0, 0, 100, 10);
        run_one("s1_forward", 0, 0, 1, 7, 1'b1);
        scene(0, 0, 0, 0, 0, 100, 10);
        run_one("s2_sideways", 1, 0, 0, 8, 1'b0);
        scene(0, 0, 0, 0, 0, 100, 10);
        run_one("s2_offaxis", 0, 10, 1, 9, 1'b0);
        scene(0, 0, 0, 0, 0, 100, 10);
        run_one("s2_behind", 0, 0, 32'hFFFF_FFFF, 10, 1'b0);
        scene(0, 0, 0, 10, 0, 100, 10);
        run_one("s3_tangent", 0, 0, 1, 11, 1'b1);
        scene(0, 0, 100, 0, 0, 100, 10);
        run_one("s3_inside", 0, 0, 32'hFFFF_FFFF, 12, 1'b1);
        scene(0, 0, 100, 0, 0, 100, 10);
        run_one("zero_ray_inside", 0, 0, 0, 13, 1'b1);
        scene(0, 0, 0, 0, 0, 100, 10);
        run_one("zero_ray_outside", 0, 0, 0, 14, 1'b0);
        scene(0, 0, 0, 0, 0, 100, 10);
        run_one("s5_trunc_one", 0, 0, 32'h0001_0001, 15, 1'b1);
        scene(0, 0, 0, 0, 0, 100, 10);
        run_one("s5_trunc_neg", 0, 0, 32'h0000_FFFF, 16, 1'b0);

        // Back-pressure: result held for 10 stalled cycles, second ray refused.
        ready_mode = 2;
        @(posedge clk); #1;
        scene(0, 0, 0, 0, 0, 100, 10);
        send(0, 0, 1, 100);
        wait_out("bp");
        s_hit = out_hit; s_idx = out_index;
        check("bp_hit", {63'd0, s_hit}, 64'd1);
        @(posedge clk); #1;
        scene(0, 0, 0, 0, 0, 100, 10);
        ray_dir_x = 0; ray_dir_y = 0; ray_dir_z = 1; pixel_index = 101; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid_held", {63'd0, out_valid}, 64'd1);
            check("bp_index_held", {32'd0, out_index}, {32'd0, s_idx});
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk); #1;
        ready_mode = 0;
        send(0, 0, 1, 101);
        wait_out("bp2");
        check("bp2_index", {32'd0, out_index}, 64'd101);
        check("bp2_hit", {63'd0, out_hit}, 64'd1);
        @(posedge clk); #1;

        // Reset while the ray is in ACC_Y.
        scene(0, 0, 0, 0, 0, 100, 10);
        send(0, 0, 1, 55);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_out_hit", {63'd0, out_hit}, 64'd0);
        check("midrst_out_colour", {40'd0, out_colour}, 64'd0);
        check("midrst_out_index", {32'd0, out_index}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_in_ready_release", {63'd0, in_ready}, 64'd1);
        repeat (12) @(posedge clk);
        #1;

        // 64 back-to-back rays with the downstream always ready.
        b2b = 1'b1;
        for (int i = 0; i < 64; i++) begin
            scene(200, 300, 0, 200 + $urandom_range(0, 40), 300, 900, $urandom_range(0, 60));
            send(rdir($urandom_range(0, 8) - 4), rdir($urandom_range(0, 8) - 4),
                 rdir($urandom_range(1, 20)), 32'(1000 + i));
        end
        for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
        #1;
        b2b = 1'b0;

        // Randomized rays with random downstream back-pressure and idle gaps.
        ready_mode = 1;
        for (int i = 0; i < 150; i++) begin
            scene($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
                  $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
                  $urandom_range(0, 400));
            vx = int'(sphere_x) - int'(camera_pos_x) + int'($urandom_range(0, 40)) - 20;
            vy = int'(sphere_y) - int'(camera_pos_y) + int'($urandom_range(0, 40)) - 20;
            vz = int'(sphere_z) - int'(camera_pos_z) + int'($urandom_range(0, 40)) - 20;
            case ($urandom_range(0, 3))
                0, 1:    send(rdir(vx), rdir(vy), rdir(vz), 32'(5000 + i));
                2:       send(rdir(-vx), rdir(-vy), rdir(-vz), 32'(5000 + i));
                default: send($urandom, $urandom, $urandom, 32'(5000 + i));
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        ready_mode = 0;
        for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "timeout");
    end

endmodule
